spi_slave_rx: RTL and testbench

SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_slave_rx_if.sv | 26 ++
 rtl/spi_rx_fifo2.sv | 50 +++++
 rtl/spi_slave_rx.sv | 127 ++++++++++++
 tb/tb_spi_slave_rx.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared SPI receive definitions: word-length default, synchronizer depth and FSM states.
`ifndef SPI_DATA_WIDTH
`define SPI_DATA_WIDTH 8
`endif

package spi_pkg;

  localparam int SPI_DEFAULT_DATA_WIDTH  = `SPI_DATA_WIDTH;
  localparam int SPI_DEFAULT_SYNC_STAGES = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_slave_rx_if.sv
// Pin and stream bundle for the SPI receiver; slave is the receiver side, master drives it.
interface spi_slave_rx_if import spi_pkg::*; #(
  parameter int DATA_WIDTH = SPI_DEFAULT_DATA_WIDTH
) ();

  logic                  sclk_in;
  logic                  cs_n_in;
  logic                  mosi_in;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  overrun;
  logic                  frame_err;
  logic                  busy;

  modport slave (
    input  sclk_in, cs_n_in, mosi_in, rx_ready,
    output rx_data, rx_valid, overrun, frame_err, busy
  );

  modport master (
    output sclk_in, cs_n_in, mosi_in, rx_ready,
    input  rx_data, rx_valid, overrun, frame_err, busy
  );

endinterface

// File: rtl/spi_rx_fifo2.sv
// Two-entry word buffer; the head entry is read straight from its register.
module spi_rx_fifo2 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  spi_clk,
  input  logic                  spi_rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem_reg [2];
  logic                  wr_ptr_reg;
  logic                  rd_ptr_reg;
  logic [1:0]            count_reg;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count_reg == 2'd0);
  assign full    = (count_reg == 2'd2);
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so a push into a full buffer still lands.
  assign do_push = push && (!full || do_pop);

  assign pop_data = mem_reg[rd_ptr_reg];

  always_ff @(posedge spi_clk) begin
    if (!spi_rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_reg[i] <= '0;
      end
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_reg[wr_ptr_reg] <= push_data;
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (do_pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_reg + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 receive-only slave: synchronizes the pins, shifts words MSB first and
// hands them to a two-entry valid/ready buffer.
module spi_slave_rx import spi_pkg::*; #(
  parameter int DATA_WIDTH  = SPI_DEFAULT_DATA_WIDTH,
  parameter int SYNC_STAGES = SPI_DEFAULT_SYNC_STAGES
) (
  input logic           spi_clk,
  input logic           spi_rst_n,
  spi_slave_rx_if.slave bus
);

  localparam int         CNT_W    = $clog2(DATA_WIDTH);
  // Bit order inside each synchronizer stage: {sclk, cs_n, mosi}.
  localparam logic [2:0] SYNC_RST = 3'b010;

  logic [2:0]            sync_reg [SYNC_STAGES];
  logic                  sclk_prev_reg;
  spi_state_e            state_reg;
  logic [CNT_W-1:0]      bit_cnt_reg;
  logic [DATA_WIDTH-2:0] shift_reg;
  logic                  frame_err_reg;
  logic                  busy_reg;
  logic                  overrun_reg;

  logic                  sclk_s;
  logic                  cs_n_s;
  logic                  mosi_s;
  logic                  sclk_rise;
  logic                  word_done;
  logic [DATA_WIDTH-1:0] shift_next;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;

  always_ff @(posedge spi_clk) begin
    if (!spi_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= SYNC_RST;
      end
    end else begin
      sync_reg[0] <= {bus.sclk_in, bus.cs_n_in, bus.mosi_in};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
    end
  end

  assign sclk_s     = sync_reg[SYNC_STAGES-1][2];
  assign cs_n_s     = sync_reg[SYNC_STAGES-1][1];
  assign mosi_s     = sync_reg[SYNC_STAGES-1][0];
  assign sclk_rise  = sclk_s && !sclk_prev_reg;
  assign word_done  = (bit_cnt_reg == CNT_W'(DATA_WIDTH - 1));
  assign shift_next = {shift_reg, mosi_s};
  // Chip-select release wins over a coincident clock edge.
  assign push       = (state_reg == SHIFT) && !cs_n_s && sclk_rise && word_done;
  assign pop        = !fifo_empty && bus.rx_ready;

  always_ff @(posedge spi_clk) begin
    if (!spi_rst_n) begin
      sclk_prev_reg <= 1'b0;
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      frame_err_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      sclk_prev_reg <= sclk_s;
      frame_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!cs_n_s) begin
            state_reg   <= SHIFT;
            busy_reg    <= 1'b1;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
          end
        end
        SHIFT: begin
          if (cs_n_s) begin
            state_reg     <= IDLE;
            busy_reg      <= 1'b0;
            frame_err_reg <= (bit_cnt_reg != '0);
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
          end else if (sclk_rise) begin
            shift_reg   <= shift_next[DATA_WIDTH-2:0];
            bit_cnt_reg <= word_done ? '0 : bit_cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge spi_clk) begin
    if (!spi_rst_n) begin
      overrun_reg <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overrun_reg <= 1'b1;
    end
  end

  spi_rx_fifo2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .spi_clk   (spi_clk),
    .spi_rst_n (spi_rst_n),
    .push      (push),
    .push_data (shift_next),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.rx_data   = fifo_head;
  assign bus.rx_valid  = !fifo_empty;
  assign bus.overrun   = overrun_reg;
  assign bus.frame_err = frame_err_reg;
  assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: directed scenarios plus random frames against a word-queue model.
module tb_spi_slave_rx;

  localparam int DW   = 8;
  localparam int SYNC = 2;
  localparam int HALF = 4;

  logic spi_clk   = 1'b0;
  logic spi_rst_n = 1'b0;

  always #5 spi_clk = ~spi_clk;

  spi_slave_rx_if #(.DATA_WIDTH(DW)) bus ();

  spi_slave_rx #(
    .DATA_WIDTH  (DW),
    .SYNC_STAGES (SYNC)
  ) dut (
    .spi_clk   (spi_clk),
    .spi_rst_n (spi_rst_n),
    .bus       (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int fe_count = 0;
  logic [DW-1:0] got_q [$];

  // Record every accepted word and every cycle frame_err is high.
  always @(negedge spi_clk) begin
    if (spi_rst_n) begin
      if (bus.rx_valid && bus.rx_ready) begin
        got_q.push_back(bus.rx_data);
        $display("[%0t] rx word 0x%02h accepted", $time, bus.rx_data);
      end
      if (bus.frame_err) fe_count++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge spi_clk);
    #1;
  endtask

  task automatic do_reset();
    spi_rst_n = 1'b0;
    tick(3);
    spi_rst_n = 1'b1;
    tick(1);
  endtask

  task automatic cs_assert();
    bus.cs_n_in = 1'b0;
    tick(SYNC + 4);
  endtask

  task automatic cs_release();
    bus.cs_n_in = 1'b1;
    tick(SYNC + 4);
  endtask

  task automatic send_bits(input logic [31:0] word, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      bus.mosi_in = word[i];
      tick(HALF);
      bus.sclk_in = 1'b1;
      tick(HALF);
      bus.sclk_in = 1'b0;
    end
  endtask

  task automatic test_reset();
    spi_rst_n = 1'b0;
    tick(3);
    if (bus.rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h need 00", bus.rx_data); end
    n_checks++;
    if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b need 0", bus.rx_valid); end
    n_checks++;
    if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b need 0", bus.overrun); end
    n_checks++;
    if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b need 0", bus.frame_err); end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b need 0", bus.busy); end
    n_checks++;
    spi_rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_single_word();
    int lat;
    bit found;
    got_q.delete();
    fe_count = 0;
    bus.rx_ready = 1'b0;
    cs_assert();
    send_bits(32'hA5 >> 1, 7);
    bus.mosi_in = 1'b1;
    tick(HALF);
    bus.sclk_in = 1'b1;
    lat = 0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick(1);
      lat++;
      if (bus.rx_valid) found = 1'b1;
    end
    if (lat !== SYNC + 1) begin n_fail++; $display("FAIL single_latency: got %0d cycles need %0d", lat, SYNC + 1); end
    n_checks++;
    tick(HALF);
    bus.sclk_in = 1'b0;
    cs_release();
    if (bus.rx_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b need 1", bus.rx_valid); end
    n_checks++;
    if (bus.rx_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h need a5", bus.rx_data); end
    n_checks++;
    if (fe_count !== 0) begin n_fail++; $display("FAIL single_frame_err: got %0d pulses need 0", fe_count); end
    n_checks++;
    if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL single_overrun: got %b need 0", bus.overrun); end
    n_checks++;
    bus.rx_ready = 1'b1;
    tick(1);
    bus.rx_ready = 1'b0;
    tick(1);
    if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop_valid: got %b need 0", bus.rx_valid); end
    n_checks++;
    if (got_q.size() !== 1) begin n_fail++; $display("FAIL single_pop_count: got %0d words need 1", got_q.size()); end
    n_checks++;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] act;
    logic [DW-1:0] exp_w [2];
    exp_w[0] = 8'h3C;
    exp_w[1] = 8'hC3;
    got_q.delete();
    bus.rx_ready = 1'b1;
    cs_assert();
    send_bits(32'h3C, 8);
    send_bits(32'hC3, 8);
    cs_release();
    if (got_q.size() !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d words need 2", got_q.size()); end
    n_checks++;
    for (int i = 0; i < 2; i++) begin
      act = (i < got_q.size()) ? got_q[i] : 'x;
      if (act !== exp_w[i]) begin n_fail++; $display("FAIL b2b_word%0d: got %h need %h", i, act, exp_w[i]); end
      n_checks++;
    end
  endtask

  task automatic test_abort();
    fe_count = 0;
    got_q.delete();
    bus.rx_ready = 1'b0;
    cs_assert();
    send_bits(32'h15, 5);
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_mid: got %b need 1", bus.busy); end
    n_checks++;
    cs_release();
    if (fe_count !== 1) begin n_fail++; $display("FAIL abort_frame_err: got %0d pulse cycles need 1", fe_count); end
    n_checks++;
    if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b need 0", bus.rx_valid); end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy_end: got %b need 0", bus.busy); end
    n_checks++;
  endtask

  task automatic test_overrun();
    logic [DW-1:0] act;
    logic [DW-1:0] exp_w [2];
    exp_w[0] = 8'h11;
    exp_w[1] = 8'h22;
    got_q.delete();
    bus.rx_ready = 1'b0;
    cs_assert();
    send_bits(32'h11, 8);
    send_bits(32'h22, 8);
    send_bits(32'h33, 8);
    cs_release();
    if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b need 1", bus.overrun); end
    n_checks++;
    bus.rx_ready = 1'b1;
    tick(4);
    bus.rx_ready = 1'b0;
    if (got_q.size() !== 2) begin n_fail++; $display("FAIL overrun_count: got %0d words need 2", got_q.size()); end
    n_checks++;
    for (int i = 0; i < 2; i++) begin
      act = (i < got_q.size()) ? got_q[i] : 'x;
      if (act !== exp_w[i]) begin n_fail++; $display("FAIL overrun_word%0d: got %h need %h", i, act, exp_w[i]); end
      n_checks++;
    end
    if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b need 1", bus.overrun); end
    n_checks++;
    do_reset();
    if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_cleared_by_reset: got %b need 0", bus.overrun); end
    n_checks++;
  endtask

  task automatic test_full_pop();
    logic [DW-1:0] act;
    logic [DW-1:0] exp_w [3];
    exp_w[0] = 8'h41;
    exp_w[1] = 8'h42;
    exp_w[2] = 8'h44;
    got_q.delete();
    bus.rx_ready = 1'b0;
    cs_assert();
    send_bits(32'h41, 8);
    send_bits(32'h42, 8);
    send_bits(32'h44 >> 1, 7);
    bus.mosi_in = 1'b0;
    tick(HALF);
    bus.sclk_in = 1'b1;
    tick(SYNC);
    bus.rx_ready = 1'b1;
    tick(1);
    bus.rx_ready = 1'b0;
    tick(HALF - SYNC - 1);
    bus.sclk_in = 1'b0;
    cs_release();
    if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL fullpop_overrun: got %b need 0", bus.overrun); end
    n_checks++;
    bus.rx_ready = 1'b1;
    tick(4);
    bus.rx_ready = 1'b0;
    if (got_q.size() !== 3) begin n_fail++; $display("FAIL fullpop_count: got %0d words need 3", got_q.size()); end
    n_checks++;
    for (int i = 0; i < 3; i++) begin
      act = (i < got_q.size()) ? got_q[i] : 'x;
      if (act !== exp_w[i]) begin n_fail++; $display("FAIL fullpop_word%0d: got %h need %h", i, act, exp_w[i]); end
      n_checks++;
    end
  endtask

  task automatic test_reset_mid_word();
    logic [DW-1:0] act;
    bus.rx_ready = 1'b0;
    cs_assert();
    send_bits(32'h5, 3);
    spi_rst_n = 1'b0;
    tick(2);
    if (bus.rx_data !== 8'h00) begin n_fail++; $display("FAIL midrst_rx_data: got %h need 00", bus.rx_data); end
    n_checks++;
    if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_rx_valid: got %b need 0", bus.rx_valid); end
    n_checks++;
    if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL midrst_overrun: got %b need 0", bus.overrun); end
    n_checks++;
    if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL midrst_frame_err: got %b need 0", bus.frame_err); end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b need 0", bus.busy); end
    n_checks++;
    bus.cs_n_in = 1'b1;
    tick(SYNC + 2);
    fe_count = 0;
    spi_rst_n = 1'b1;
    tick(SYNC + 2);
    got_q.delete();
    bus.rx_ready = 1'b1;
    cs_assert();
    send_bits(32'h5A, 8);
    cs_release();
    if (got_q.size() !== 1) begin n_fail++; $display("FAIL midrst_count: got %0d words need 1", got_q.size()); end
    n_checks++;
    act = (got_q.size() > 0) ? got_q[0] : 'x;
    if (act !== 8'h5A) begin n_fail++; $display("FAIL midrst_word: got %h need 5a", act); end
    n_checks++;
    if (fe_count !== 0) begin n_fail++; $display("FAIL midrst_no_frame_err: got %0d pulses need 0", fe_count); end
    n_checks++;
  endtask

  // Model: every complete word of a frame is delivered in order, a trailing
  // partial word is dropped and costs exactly one frame_err pulse.
  task automatic test_random_frames();
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] word;
    logic [DW-1:0] act;
    int nwords;
    int partial;
    int exp_fe;
    bus.rx_ready = 1'b1;
    for (int f = 0; f < 20; f++) begin
      exp_q.delete();
      got_q.delete();
      fe_count = 0;
      nwords  = $urandom_range(1, 3);
      partial = $urandom_range(0, DW - 1);
      exp_fe  = (partial != 0) ? 1 : 0;
      cs_assert();
      for (int w = 0; w < nwords; w++) begin
        word = DW'($urandom_range(0, 255));
        exp_q.push_back(word);
        send_bits(32'(word), DW);
      end
      if (partial != 0) send_bits($urandom, partial);
      cs_release();
      if (got_q.size() !== exp_q.size()) begin
        n_fail++;
        $display("FAIL rand%0d_count: got %0d words need %0d", f, got_q.size(), exp_q.size());
      end
      n_checks++;
      for (int i = 0; i < exp_q.size(); i++) begin
        act = (i < got_q.size()) ? got_q[i] : 'x;
        if (act !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_word%0d: got %h need %h", f, i, act, exp_q[i]); end
        n_checks++;
      end
      if (fe_count !== exp_fe) begin n_fail++; $display("FAIL rand%0d_frame_err: got %0d need %0d", f, fe_count, exp_fe); end
      n_checks++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rand%0d_busy: got %b need 0", f, bus.busy); end
      n_checks++;
    end
    if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL rand_overrun: got %b need 0", bus.overrun); end
    n_checks++;
  endtask

  initial begin
    bus.sclk_in  = 1'b0;
    bus.cs_n_in  = 1'b1;
    bus.mosi_in  = 1'b0;
    bus.rx_ready = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_abort();
    test_overrun();
    test_full_pop();
    test_reset_mid_word();
    test_random_frames();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
